// File: rtl/riscv_muldiv.sv
// Iterative RV32M execute unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with sign correction folded into the final iteration.
module riscv_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_op_a,
    input  logic [XLEN-1:0] req_op_b,
    input  logic            kill,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            busy
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              neg_q, neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic              is_div, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b;

    // Request decode: which operands are signed, their magnitudes, special cases
    always_comb begin
        a_signed = (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                   (req_funct3 == 3'b100) || (req_funct3 == 3'b110);
        b_signed = (req_funct3 == 3'b001) || (req_funct3 == 3'b100) ||
                   (req_funct3 == 3'b110);
        a_neg    = a_signed & req_op_a[XLEN-1];
        b_neg    = b_signed & req_op_b[XLEN-1];
        mag_a    = a_neg ? -req_op_a : req_op_a;
        mag_b    = b_neg ? -req_op_b : req_op_b;
        is_div   = req_funct3[2];
        div_zero = is_div && (req_op_b == '0);
        div_ovf  = is_div && !req_funct3[0] &&
                   (req_op_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_op_b == '1);
    end

    logic [XLEN:0]     mul_sum, div_trial, div_diff;
    logic [2*XLEN-1:0] acc_step, product;
    logic [XLEN-1:0]   quot, rem, final_result;

    // One iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_trial - {1'b0, opb_q};
        if (funct3_q[2]) begin
            if (!div_diff[XLEN]) begin
                acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_step = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
        product = neg_q ? -acc_step : acc_step;
        quot    = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem     = rem_neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        case (funct3_q)
            3'b000:         final_result = product[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:         final_result = product[2*XLEN-1:XLEN];
            3'b100, 3'b101: final_result = quot;
            default:        final_result = rem;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        funct3_d  = funct3_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (req_valid && !kill) begin
                    funct3_d  = req_funct3;
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    cnt_d     = '0;
                    acc_d     = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                    opb_d     = is_div ? mag_b : mag_a;
                    if (div_zero) begin
                        result_d = req_funct3[1] ? req_op_a : '1;
                        state_d  = DONE;
                    end else if (div_ovf) begin
                        result_d = req_funct3[1] ? '0 : req_op_a;
                        state_d  = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        result_d = final_result;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (kill || rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            funct3_q  <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            funct3_q  <= funct3_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign rsp_result = result_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Self-checking bench for riscv_muldiv: scoreboarded directed and random
// operations, special cases, backpressure, kill and mid-operation reset.
module tb_riscv_muldiv;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [2:0]      req_funct3 = '0;
    logic [XLEN-1:0] req_op_a = '0;
    logic [XLEN-1:0] req_op_b = '0;
    logic            kill = 1'b0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [XLEN-1:0] rsp_result;
    logic            busy;

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] exp_q[$];

    riscv_muldiv #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_op_a   (req_op_a),
        .req_op_b   (req_op_b),
        .kill       (kill),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference results from plain SystemVerilog arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0)) return 1;
        if (f[2] && !f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    // Drives one request, pushes its expectation, returns observed latency and result
    task automatic issue_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, output int lat, output logic [31:0] res);
        int guard;
        exp_q.push_back(exp_res);
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        req_funct3 = f3;
        req_op_a   = a;
        req_op_b   = b;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_op_a   = $urandom;
        req_op_b   = $urandom;
        req_funct3 = 3'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = rsp_result;
        if (rsp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %b, expected 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b, expected 0", rsp_valid); end
        checks++; if (rsp_result !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp_result: got %h, expected 0", rsp_result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [2:0]  fv [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd1, 3'd4, 3'd6, 3'd5, 3'd7, 3'd0, 3'd3, 3'd7};
        logic [31:0] av [12] = '{32'h7, 32'h7, 32'h7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9,
                                 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h64};
        logic [31:0] bv [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h2,
                                 32'h2, 32'h2, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7};
        logic [31:0] ev [12] = '{32'hFFFF_FFEB, 32'h6, 32'hFFFF_FFFF, 32'h8000_0000, 32'h4000_0000, 32'hFFFF_FFFD,
                                 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h1, 32'h1, 32'hFFFF_FFFE, 32'h2};
        int lat;
        logic [31:0] res, exp_r;
        for (int i = 0; i < 12; i++) begin
            issue_op(fv[i], av[i], bv[i], ev[i], lat, res);
            exp_r = exp_q.pop_front();
            checks++; if (lat != 33) begin errors++; $display("[TB] FAIL directed_latency[%0d]: got %0d, expected 33", i, lat); end
            checks++; if (res !== exp_r) begin errors++; $display("[TB] FAIL directed_result[%0d]: got %h, expected %h", i, res, exp_r); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  fv [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] av [6] = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ev [6] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'h0};
        int lat;
        logic [31:0] res, exp_r;
        for (int i = 0; i < 6; i++) begin
            issue_op(fv[i], av[i], bv[i], ev[i], lat, res);
            exp_r = exp_q.pop_front();
            checks++; if (lat != 1) begin errors++; $display("[TB] FAIL special_latency[%0d]: got %0d, expected 1", i, lat); end
            checks++; if (res !== exp_r) begin errors++; $display("[TB] FAIL special_result[%0d]: got %h, expected %h", i, res, exp_r); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, res, exp_r;
        int lat, exp_lat;
        for (int i = 0; i < 16; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            exp_lat = model_lat(f, a, b);
            issue_op(f, a, b, model(f, a, b), lat, res);
            exp_r = exp_q.pop_front();
            checks++; if (lat != exp_lat) begin errors++; $display("[TB] FAIL random_latency[%0d] f=%0d a=%h b=%h: got %0d, expected %0d", i, f, a, b, lat, exp_lat); end
            checks++; if (res !== exp_r) begin errors++; $display("[TB] FAIL random_result[%0d] f=%0d a=%h b=%h: got %h, expected %h", i, f, a, b, res, exp_r); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] res, exp_r;
        rsp_ready = 1'b0;
        issue_op(3'd5, 32'd100, 32'd7, 32'd14, lat, res);
        exp_r = exp_q.pop_front();
        checks++; if (lat != 33) begin errors++; $display("[TB] FAIL bp_latency: got %0d, expected 33", lat); end
        checks++; if (res !== exp_r) begin errors++; $display("[TB] FAIL bp_result: got %h, expected %h", res, exp_r); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid[%0d]: got %b, expected 1", i, rsp_valid); end
            checks++; if (rsp_result !== exp_r) begin errors++; $display("[TB] FAIL bp_hold_result[%0d]: got %h, expected %h", i, rsp_result, exp_r); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold_req_ready[%0d]: got %b, expected 0", i, req_ready); end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_valid: got %b, expected 0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_req_ready: got %b, expected 1", req_ready); end
        checks++; if (rsp_result !== exp_r) begin errors++; $display("[TB] FAIL bp_release_result: got %h, expected %h", rsp_result, exp_r); end
        issue_op(3'd3, 32'h7, 32'hFFFF_FFFD, 32'h6, lat, res);
        exp_r = exp_q.pop_front();
        checks++; if (lat != 33) begin errors++; $display("[TB] FAIL bp_next_latency: got %0d, expected 33", lat); end
        checks++; if (res !== exp_r) begin errors++; $display("[TB] FAIL bp_next_result: got %h, expected %h", res, exp_r); end
    endtask

    task automatic test_kill();
        int seen;
        // Kill coincident with a request in IDLE: nothing accepted
        req_funct3 = 3'd0; req_op_a = 32'd9; req_op_b = 32'd9;
        req_valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; kill = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL kill_idle_busy: got %b, expected 0", busy); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL kill_idle_req_ready: got %b, expected 1", req_ready); end
        // Kill mid-calculation at counter 15
        req_funct3 = 3'd4; req_op_a = 32'd1000; req_op_b = 32'd3;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL kill_calc_busy: got %b, expected 1", busy); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL kill_calc_req_ready: got %b, expected 0", req_ready); end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL kill_req_ready: got %b, expected 1", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL kill_busy: got %b, expected 0", busy); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen != 0) begin errors++; $display("[TB] FAIL kill_no_response: got %0d valid cycles, expected 0", seen); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [31:0] res, exp_r;
        req_funct3 = 3'd1; req_op_a = 32'h1234_5678; req_op_b = 32'h8765_4321;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_req_ready: got %b, expected 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_rsp_valid: got %b, expected 0", rsp_valid); end
        checks++; if (rsp_result !== 32'h0) begin errors++; $display("[TB] FAIL midreset_rsp_result: got %h, expected 0", rsp_result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b, expected 0", busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue_op(3'd0, 32'd3, 32'd5, 32'd15, lat, res);
        exp_r = exp_q.pop_front();
        checks++; if (lat != 33) begin errors++; $display("[TB] FAIL post_reset_latency: got %0d, expected 33", lat); end
        checks++; if (res !== exp_r) begin errors++; $display("[TB] FAIL post_reset_result: got %h, expected %h", res, exp_r); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_special();
        test_random();
        test_backpressure();
        test_kill();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
